dispensador_troco: RTL and testbench

//  Change (troco) dispenser: the output-side counterpart of the note-input decoder. Takes an 8-bit

---
 rtl/troco_pkg.sv | 43 ++++
 rtl/selecionador_nota.sv | 42 ++++
 rtl/dispensador_troco.sv | 175 +++++++++++++++++
 tb/tb_dispensador_troco.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/troco_pkg.sv
// troco_pkg: shared definitions for the change dispenser.
//   - 3-bit note codes (same encoding as the note-entry decoder)
//   - note face values in R$
//   - erro_code values
//   - dispenser FSM state type
package troco_pkg;

    localparam logic [2:0] NOTA_NENHUMA = 3'b000;
    localparam logic [2:0] NOTA_2       = 3'b001;
    localparam logic [2:0] NOTA_5       = 3'b010;
    localparam logic [2:0] NOTA_10      = 3'b011;
    localparam logic [2:0] NOTA_20      = 3'b100;
    localparam logic [2:0] NOTA_50      = 3'b101;
    localparam logic [2:0] NOTA_100     = 3'b110;
    localparam logic [2:0] NOTA_200     = 3'b111;

    localparam logic [2:0] ERRO_OK        = 3'b000;
    localparam logic [2:0] ERRO_SEM_TROCO = 3'b001;
    localparam logic [2:0] ERRO_CANCELADO = 3'b010;
    localparam logic [2:0] ERRO_TIMEOUT   = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_OFFER,
        S_END
    } estado_t;

    // Face value in R$ of a note code; 0 for the idle code.
    function automatic logic [7:0] valor_nota(input logic [2:0] code);
        case (code)
            NOTA_2:   valor_nota = 8'd2;
            NOTA_5:   valor_nota = 8'd5;
            NOTA_10:  valor_nota = 8'd10;
            NOTA_20:  valor_nota = 8'd20;
            NOTA_50:  valor_nota = 8'd50;
            NOTA_100: valor_nota = 8'd100;
            NOTA_200: valor_nota = 8'd200;
            default:  valor_nota = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/selecionador_nota.sv
// selecionador_nota: combinational note picker.
//   rem        in   W  remaining amount
//   code       out  3  largest note n <= rem such that (rem - n) is not 1 or 3
//   valor      out  8  face value of the chosen note (0 if none)
//   impossivel out  1  rem is 1 or 3: no exact change possible
// With rem == 0 no note is chosen and impossivel stays 0.
module selecionador_nota
    import troco_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] rem,
    output logic [2:0]   code,
    output logic [7:0]   valor,
    output logic         impossivel
);

    logic        w_found;
    int unsigned w_rem;
    int unsigned w_nv;

    always_comb begin
        code       = NOTA_NENHUMA;
        valor      = '0;
        w_found    = 1'b0;
        w_rem      = 32'(rem);
        w_nv       = 0;
        impossivel = (w_rem == 1) || (w_rem == 3);
        // Scan from the largest code down; the first acceptable note wins.
        // Never leaving 1 or 3 behind keeps every later step solvable.
        for (int unsigned c = 7; c >= 1; c--) begin
            w_nv = 32'(valor_nota(c[2:0]));
            if (!w_found && !impossivel && (w_nv <= w_rem) &&
                ((w_rem - w_nv) != 1) && ((w_rem - w_nv) != 3)) begin
                w_found = 1'b1;
                code    = c[2:0];
                valor   = valor_nota(c[2:0]);
            end
        end
    end

endmodule

// File: rtl/dispensador_troco.sv
// dispensador_troco: issues a change amount as a sequence of notes,
// one per nota_valid/nota_ack handshake.
//   clk          in   1  clock, rising edge
//   rst_n        in   1  synchronous active-low reset
//   start        in   1  latch valor_troco and begin (ignored while busy)
//   cancela      in   1  abort current dispense
//   valor_troco  in   W  change amount in R$
//   nota_ack     in   1  mechanism accepted the offered note
//   nota_valid   out  1  nota_code valid, held until acked
//   nota_code    out  3  offered note code (000 when not offering)
//   busy         out  1  dispense in progress
//   done         out  1  one-cycle pulse at end of operation
//   erro_code    out  3  result of last operation, held until next start
//   qtd_notas    out  8  notes acked in current/last operation
module dispensador_troco
    import troco_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cancela,
    input  logic [W-1:0] valor_troco,
    input  logic         nota_ack,
    output logic         nota_valid,
    output logic [2:0]   nota_code,
    output logic         busy,
    output logic         done,
    output logic [2:0]   erro_code,
    output logic [7:0]   qtd_notas
);

    localparam int unsigned TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] CNT_LAST = TW'(ACK_TIMEOUT - 1);

    estado_t       r_state, w_state_n;
    logic [W-1:0]  r_rem,   w_rem_n;
    logic [7:0]    r_valor, w_valor_n;
    logic [TW-1:0] r_cnt,   w_cnt_n;
    logic [7:0]    r_qtd,   w_qtd_n;
    logic          r_valid, w_valid_n;
    logic [2:0]    r_code,  w_code_n;
    logic          r_busy,  w_busy_n;
    logic          r_done,  w_done_n;
    logic [2:0]    r_erro,  w_erro_n;

    logic [2:0]    w_sel_code;
    logic [7:0]    w_sel_valor;
    logic          w_sel_impossivel;

    selecionador_nota #(.W(W)) u_sel (
        .rem        (r_rem),
        .code       (w_sel_code),
        .valor      (w_sel_valor),
        .impossivel (w_sel_impossivel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_valor <= '0;
            r_cnt   <= '0;
            r_qtd   <= '0;
            r_valid <= 1'b0;
            r_code  <= NOTA_NENHUMA;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_erro  <= ERRO_OK;
        end else begin
            r_state <= w_state_n;
            r_rem   <= w_rem_n;
            r_valor <= w_valor_n;
            r_cnt   <= w_cnt_n;
            r_qtd   <= w_qtd_n;
            r_valid <= w_valid_n;
            r_code  <= w_code_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_erro  <= w_erro_n;
        end
    end

    // Outputs are registered: done is set on the edge entering END so it is
    // high exactly during the END cycle; valid/code are set on SELECT->OFFER.
    always_comb begin
        w_state_n = r_state;
        w_rem_n   = r_rem;
        w_valor_n = r_valor;
        w_cnt_n   = r_cnt;
        w_qtd_n   = r_qtd;
        w_valid_n = r_valid;
        w_code_n  = r_code;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        w_erro_n  = r_erro;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_rem_n   = valor_troco;
                    w_qtd_n   = '0;
                    w_cnt_n   = '0;
                    w_erro_n  = ERRO_OK;
                    w_busy_n  = 1'b1;
                    w_state_n = S_SELECT;
                end
            end

            S_SELECT: begin
                if (cancela) begin
                    w_erro_n  = ERRO_CANCELADO;
                    w_done_n  = 1'b1;
                    w_state_n = S_END;
                end else if (r_rem == '0) begin
                    w_erro_n  = ERRO_OK;
                    w_done_n  = 1'b1;
                    w_state_n = S_END;
                end else if (w_sel_impossivel) begin
                    w_erro_n  = ERRO_SEM_TROCO;
                    w_done_n  = 1'b1;
                    w_state_n = S_END;
                end else begin
                    w_code_n  = w_sel_code;
                    w_valor_n = w_sel_valor;
                    w_valid_n = 1'b1;
                    w_cnt_n   = '0;
                    w_state_n = S_OFFER;
                end
            end

            S_OFFER: begin
                if (cancela) begin
                    w_valid_n = 1'b0;
                    w_code_n  = NOTA_NENHUMA;
                    w_erro_n  = ERRO_CANCELADO;
                    w_done_n  = 1'b1;
                    w_state_n = S_END;
                end else if (nota_ack) begin
                    w_rem_n   = r_rem - W'(r_valor);
                    w_qtd_n   = r_qtd + 8'd1;
                    w_cnt_n   = '0;
                    w_valid_n = 1'b0;
                    w_code_n  = NOTA_NENHUMA;
                    w_state_n = S_SELECT;
                end else if (r_cnt == CNT_LAST) begin
                    w_valid_n = 1'b0;
                    w_code_n  = NOTA_NENHUMA;
                    w_erro_n  = ERRO_TIMEOUT;
                    w_done_n  = 1'b1;
                    w_state_n = S_END;
                end else begin
                    w_cnt_n = r_cnt + TW'(1);
                end
            end

            S_END: begin
                w_busy_n  = 1'b0;
                w_state_n = S_IDLE;
            end

            default: w_state_n = S_IDLE;
        endcase
    end

    assign nota_valid = r_valid;
    assign nota_code  = r_code;
    assign busy       = r_busy;
    assign done       = r_done;
    assign erro_code  = r_erro;
    assign qtd_notas  = r_qtd;

endmodule

// File: tb/tb_dispensador_troco.sv
module tb_dispensador_troco;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cancela;
    logic [7:0] valor_troco;
    logic       nota_ack;
    logic       nota_valid;
    logic [2:0] nota_code;
    logic       busy;
    logic       done;
    logic [2:0] erro_code;
    logic [7:0] qtd_notas;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [2:0]  exp_q [$];

    dispensador_troco #(.W(8), .ACK_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cancela     (cancela),
        .valor_troco (valor_troco),
        .nota_ack    (nota_ack),
        .nota_valid  (nota_valid),
        .nota_code   (nota_code),
        .busy        (busy),
        .done        (done),
        .erro_code   (erro_code),
        .qtd_notas   (qtd_notas)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full dispense with prompt acks; exp_q holds the expected note codes.
    task automatic run(input logic [7:0] v, input logic [2:0] exp_erro, input logic [7:0] exp_qtd);
        int unsigned idx;
        int unsigned cyc;
        logic        got_done;
        idx      = 0;
        cyc      = 1;
        got_done = 1'b0;
        start = 1'b1; valor_troco = v;
        tick();
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        while (cyc < 100 && !got_done) begin
            if (done) begin
                got_done = 1'b1;
            end else if (nota_valid) begin
                if (idx == 0) check_eq("first_valid_latency", cyc, 2);
                if (idx < exp_q.size()) check_eq("note_code", nota_code, exp_q[idx]);
                else check_eq("note_overrun", idx + 1, exp_q.size());
                idx++;
                nota_ack = 1'b1;
                tick();
                nota_ack = 1'b0;
                cyc++;
                check_eq("gap_valid_low", nota_valid, 0);
                check_eq("qtd_running", qtd_notas, idx);
            end else begin
                tick();
                cyc++;
            end
        end
        check_eq("done_seen", got_done, 1);
        check_eq("note_count", idx, exp_q.size());
        check_eq("erro_end", erro_code, exp_erro);
        check_eq("qtd_end", qtd_notas, exp_qtd);
        if (exp_q.size() == 0) check_eq("done_latency", cyc, 2);
        tick();
        check_eq("done_pulse_end", done, 0);
        check_eq("busy_end", busy, 0);
        check_eq("code_idle", nota_code, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        rst_n = 1'b0; start = 1'b0; cancela = 1'b0; nota_ack = 1'b0; valor_troco = '0;
        tick(); tick();
        check_eq("rst_valid", nota_valid, 0);
        check_eq("rst_code", nota_code, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_erro", erro_code, 0);
        check_eq("rst_qtd", qtd_notas, 0);
        rst_n = 1'b1;
        tick();

        // 187 = 100+50+20+10+5+2
        exp_q = '{3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001};
        run(8'd187, 3'b000, 8'd6);
        // 6 = 2+2+2 (5 would leave 1)
        exp_q = '{3'b001, 3'b001, 3'b001};
        run(8'd6, 3'b000, 8'd3);
        // 255 = 200+50+5
        exp_q = '{3'b111, 3'b101, 3'b010};
        run(8'd255, 3'b000, 8'd3);
        // 8 = 2+2+2+2 (5 would leave 3)
        exp_q = '{3'b001, 3'b001, 3'b001, 3'b001};
        run(8'd8, 3'b000, 8'd4);
        // No exact change / zero
        exp_q.delete();
        run(8'd3, 3'b001, 8'd0);
        run(8'd1, 3'b001, 8'd0);
        run(8'd0, 3'b000, 8'd0);

        // Ack withheld: valid for ACK_TIMEOUT=4 cycles, then timeout
        start = 1'b1; valor_troco = 8'd10;
        tick(); start = 1'b0;
        tick();
        n = 0;
        while (nota_valid && n < 20) begin
            n++;
            tick();
        end
        check_eq("to_valid_cycles", n, 4);
        check_eq("to_done", done, 1);
        check_eq("to_erro", erro_code, 3);
        check_eq("to_qtd", qtd_notas, 0);
        tick();
        check_eq("to_busy", busy, 0);

        // Cancel during OFFER of second note of 187
        start = 1'b1; valor_troco = 8'd187;
        tick(); start = 1'b0;
        tick();
        check_eq("cx_code1", nota_code, 3'b110);
        nota_ack = 1'b1; tick(); nota_ack = 1'b0;
        tick();
        check_eq("cx_valid2", nota_valid, 1);
        check_eq("cx_code2", nota_code, 3'b101);
        cancela = 1'b1; nota_ack = 1'b1; tick(); cancela = 1'b0; nota_ack = 1'b0;
        check_eq("cx_valid_drop", nota_valid, 0);
        check_eq("cx_done", done, 1);
        check_eq("cx_erro", erro_code, 2);
        check_eq("cx_qtd", qtd_notas, 1);
        check_eq("cx_code_idle", nota_code, 0);
        tick();

        // start while busy ignored; ack while valid=0 ignored (12 = 10+2)
        start = 1'b1; valor_troco = 8'd12;
        tick();
        valor_troco = 8'd4; nota_ack = 1'b1;
        tick();
        start = 1'b0; nota_ack = 1'b0;
        check_eq("bz_code", nota_code, 3'b011);
        check_eq("bz_qtd_sel_ack", qtd_notas, 0);
        tick();
        check_eq("bz_still_valid", nota_valid, 1);
        nota_ack = 1'b1; tick();
        check_eq("bz_qtd1", qtd_notas, 1);
        tick();
        nota_ack = 1'b0;
        check_eq("bz_qtd_gap_ack", qtd_notas, 1);
        check_eq("bz_code2", nota_code, 3'b001);
        nota_ack = 1'b1; tick(); nota_ack = 1'b0;
        check_eq("bz_qtd2", qtd_notas, 2);
        tick();
        check_eq("bz_done", done, 1);
        check_eq("bz_erro", erro_code, 0);
        tick();

        // start and cancela together in IDLE: start wins
        start = 1'b1; cancela = 1'b1; valor_troco = 8'd0;
        tick(); start = 1'b0; cancela = 1'b0;
        check_eq("sc_busy", busy, 1);
        tick();
        check_eq("sc_done", done, 1);
        check_eq("sc_erro", erro_code, 0);
        tick();

        // Reset mid-OFFER
        start = 1'b1; valor_troco = 8'd187;
        tick(); start = 1'b0;
        tick();
        nota_ack = 1'b1; tick(); nota_ack = 1'b0;
        tick();
        check_eq("rm_valid_before", nota_valid, 1);
        rst_n = 1'b0;
        tick();
        check_eq("rm_valid", nota_valid, 0);
        check_eq("rm_code", nota_code, 0);
        check_eq("rm_busy", busy, 0);
        check_eq("rm_done", done, 0);
        check_eq("rm_erro", erro_code, 0);
        check_eq("rm_qtd", qtd_notas, 0);
        rst_n = 1'b1;
        tick();

        exp_q = '{3'b111, 3'b101, 3'b010};
        run(8'd255, 3'b000, 8'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
